// File: rtl/ssd1306_pkg.sv
// ssd1306_pkg: shared opcode constants, FIFO entry layout and state types
// for the SSD1306 SPI receiver slice.
package ssd1306_pkg;

    localparam logic [7:0] OP_DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] OP_SET_CONTRAST   = 8'h81;
    localparam logic [7:0] OP_DISPLAY_OFFSET = 8'hD3;
    localparam logic [7:0] OP_COM_PINS       = 8'hDA;
    localparam logic [7:0] OP_VCOMH_LEVEL    = 8'hDB;
    localparam logic [7:0] OP_CLOCK_DIV      = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE      = 8'hD9;
    localparam logic [7:0] OP_MUX_RATIO      = 8'hA8;
    localparam logic [7:0] OP_CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] OP_ADDR_MODE      = 8'h20;

    localparam logic [7:0] CONTRAST_RESET = 8'h7F;

    localparam int unsigned RX_ENTRY_W = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       param;
    } rx_entry_t;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    typedef enum logic {
        DEC_OPCODE,
        DEC_PARAM
    } dec_state_t;

    // Opcodes whose next command byte is a parameter
    function automatic logic has_param(input logic [7:0] op);
        case (op)
            OP_SET_CONTRAST, OP_DISPLAY_OFFSET, OP_COM_PINS, OP_VCOMH_LEVEL,
            OP_CLOCK_DIV, OP_PRECHARGE, OP_MUX_RATIO, OP_CHARGE_PUMP,
            OP_ADDR_MODE: has_param = 1'b1;
            default:      has_param = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_rx_if.sv
// ssd1306_spi_rx_if: received-byte stream from the SPI receiver to its consumer.
interface ssd1306_spi_rx_if;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_param;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_dc,
        output rx_param,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_dc,
        input  rx_param,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/ssd1306_rx_fifo.sv
// ssd1306_rx_fifo: first-word-fall-through FIFO of received entries.
// A push while full is accepted only when a pop happens in the same cycle.
module ssd1306_rx_fifo
    import ssd1306_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rx_entry_t wr_entry,
    input  logic      pop,
    output rx_entry_t rd_entry,
    output logic      full,
    output logic      empty,
    output logic      push_ok
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    rx_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        pop_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head entry reads as zero while empty so the outputs have a defined reset value
    assign rd_entry = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update on accepted push/pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx: SPI mode-0 slave that captures SSD1306 command/data bytes
// into a FWFT FIFO. Optional command decoder enabled by defining
// SSD1306_RX_CMD_DECODE_EN (tracks display on/off, contrast, parameter tags).
module ssd1306_spi_rx
    import ssd1306_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     oled_sclk,
    input  logic                     oled_sdin,
    input  logic                     oled_dc,
    input  logic                     ss,
    ssd1306_spi_rx_if.master         rx,
    output logic                     rx_overflow,
    output logic                     frame_err,
    output logic [15:0]              byte_count,
    output logic                     display_on,
    output logic [7:0]               contrast
);

    logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, dc_sync, ss_sync;
    logic sclk_s, sdin_s, dc_s, ss_s;

    rx_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       sclk_prev_q;
    logic       armed_q;
    logic       sclk_rise;
    logic       push;
    logic       frame_err_d;
    logic       push_ok;
    logic       fifo_full, fifo_empty;
    logic       param_tag;
    rx_entry_t  push_entry, head;

    // Input synchronizers; ss chain resets low so a held-low ss never looks like a fresh fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            sdin_sync <= '0;
            dc_sync   <= '0;
            ss_sync   <= '0;
        end else begin
            sclk_sync[0] <= oled_sclk;
            sdin_sync[0] <= oled_sdin;
            dc_sync[0]   <= oled_dc;
            ss_sync[0]   <= ss;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                sdin_sync[i] <= sdin_sync[i-1];
                dc_sync[i]   <= dc_sync[i-1];
                ss_sync[i]   <= ss_sync[i-1];
            end
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdin_s    = sdin_sync[SYNC_STAGES-1];
    assign dc_s      = dc_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev_q;

    // Receive FSM state, shift register, edge history and arming flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            sclk_prev_q <= sclk_s;
            armed_q     <= armed_q | ss_s;
            frame_err   <= frame_err_d;
        end
    end

    // Receive FSM next state: shift on sclk rise, push on 8th bit, flag partial frames
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!ss_s && armed_q) begin
                    state_d   = RX_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            RX_SHIFT: begin
                if (ss_s) begin
                    state_d     = RX_IDLE;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = '0;
                end else if (sclk_rise) begin
                    shreg_d   = {shreg_q[6:0], sdin_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    push      = (bit_cnt_q == 3'd7);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign push_entry = '{data: {shreg_q[6:0], sdin_s}, dc: dc_s, param: param_tag};

    ssd1306_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (push_entry),
        .pop      (rx.rx_valid && rx.rx_ready),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .push_ok  (push_ok)
    );

    assign rx.rx_data  = head.data;
    assign rx.rx_dc    = head.dc;
    assign rx.rx_param = head.param;
    assign rx.rx_valid = !fifo_empty;

    // Sticky overflow and accepted-byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_overflow <= 1'b0;
            byte_count  <= '0;
        end else begin
            if (push && !push_ok) rx_overflow <= 1'b1;
            if (push_ok)          byte_count  <= byte_count + 16'd1;
        end
    end

`ifdef SSD1306_RX_CMD_DECODE_EN
    dec_state_t dec_state_q, dec_state_d;
    logic [7:0] pending_op_q, pending_op_d;
    logic       display_on_d;
    logic [7:0] contrast_d;

    assign param_tag = (dec_state_q == DEC_PARAM) && !dc_s;

    // Decoder state and tracked display settings
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_state_q  <= DEC_OPCODE;
            pending_op_q <= '0;
            display_on   <= 1'b0;
            contrast     <= CONTRAST_RESET;
        end else begin
            dec_state_q  <= dec_state_d;
            pending_op_q <= pending_op_d;
            display_on   <= display_on_d;
            contrast     <= contrast_d;
        end
    end

    // Decoder next state: only accepted command bytes advance it
    always_comb begin
        dec_state_d  = dec_state_q;
        pending_op_d = pending_op_q;
        display_on_d = display_on;
        contrast_d   = contrast;
        if (push_ok && !dc_s) begin
            case (dec_state_q)
                DEC_OPCODE: begin
                    if (push_entry.data == OP_DISPLAY_OFF) display_on_d = 1'b0;
                    if (push_entry.data == OP_DISPLAY_ON)  display_on_d = 1'b1;
                    if (has_param(push_entry.data)) begin
                        dec_state_d  = DEC_PARAM;
                        pending_op_d = push_entry.data;
                    end
                end
                DEC_PARAM: begin
                    if (pending_op_q == OP_SET_CONTRAST) contrast_d = push_entry.data;
                    dec_state_d = DEC_OPCODE;
                end
                default: dec_state_d = DEC_OPCODE;
            endcase
        end
    end
`else
    assign param_tag  = 1'b0;
    assign display_on = 1'b0;
    assign contrast   = CONTRAST_RESET;
`endif

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// tb_ssd1306_spi_rx: directed table-driven bench for ssd1306_spi_rx.
// Expectations follow SSD1306_RX_CMD_DECODE_EN when it is defined.
module tb_ssd1306_spi_rx;

`ifdef SSD1306_RX_CMD_DECODE_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        oled_sclk, oled_sdin, oled_dc, ss;
    logic        rx_overflow, frame_err, display_on;
    logic [15:0] byte_count;
    logic [7:0]  contrast;

    ssd1306_spi_rx_if rx_if ();

    ssd1306_spi_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .oled_sclk   (oled_sclk),
        .oled_sdin   (oled_sdin),
        .oled_dc     (oled_dc),
        .ss          (ss),
        .rx          (rx_if),
        .rx_overflow (rx_overflow),
        .frame_err   (frame_err),
        .byte_count  (byte_count),
        .display_on  (display_on),
        .contrast    (contrast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt   = 0;
    int pop_cnt  = 0;
    logic [7:0] last_pop = '0;

    // Count frame_err cycles and record handshaked bytes
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (rx_if.rx_valid && rx_if.rx_ready) begin
            pop_cnt++;
            last_pop = rx_if.rx_data;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0, MSB first, sclk = clk/8
    task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            oled_sdin = b[7-i];
            oled_dc   = dc;
            clks(4);
            oled_sclk = 1'b1;
            clks(4);
            oled_sclk = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 64 && !rx_if.rx_valid; k++) @(negedge clk);
        check(name, rx_if.rx_valid, 1);
    endtask

    task automatic pop_one();
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rx_valid"},    rx_if.rx_valid, 0);
        check({tag, ".rx_data"},     rx_if.rx_data, 0);
        check({tag, ".rx_dc"},       rx_if.rx_dc, 0);
        check({tag, ".rx_param"},    rx_if.rx_param, 0);
        check({tag, ".rx_overflow"}, rx_overflow, 0);
        check({tag, ".frame_err"},   frame_err, 0);
        check({tag, ".byte_count"},  byte_count, 0);
        check({tag, ".display_on"},  display_on, 0);
        check({tag, ".contrast"},    contrast, 8'h7F);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ss  = 1'b1;
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(4);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       exp_param;
        logic       exp_disp;
        logic [7:0] exp_contrast;
    } vec_t;

    vec_t vecs [9];

    initial begin
        // data, dc, rx_param, display_on, contrast (decoder build)
        vecs[0] = '{8'hAF, 1'b0, 1'b0, 1'b1, 8'h7F};
        vecs[1] = '{8'h81, 1'b0, 1'b0, 1'b1, 8'h7F};
        vecs[2] = '{8'h3C, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[4] = '{8'h20, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[5] = '{8'hD3, 1'b0, 1'b0, 1'b1, 8'h3C};
        vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h3C};
        vecs[7] = '{8'h10, 1'b0, 1'b1, 1'b1, 8'h3C};
        vecs[8] = '{8'hAE, 1'b0, 1'b0, 1'b0, 8'h3C};

        rst = 1'b1;
        oled_sclk = 1'b0;
        oled_sdin = 1'b0;
        oled_dc   = 1'b0;
        ss        = 1'b1;
        rx_if.rx_ready = 1'b0;
        clks(3);
        check_reset_values("reset");
        rst = 1'b0;
        clks(4);

        // Table: one byte at a time, checked at the FIFO head, then popped
        ss = 1'b0;
        clks(4);
        for (int i = 0; i < 9; i++) begin
            send_bits(vecs[i].data, vecs[i].dc, 8);
            wait_valid($sformatf("vec%0d.valid", i));
            check($sformatf("vec%0d.rx_data", i),    rx_if.rx_data, vecs[i].data);
            check($sformatf("vec%0d.rx_dc", i),      rx_if.rx_dc, vecs[i].dc);
            check($sformatf("vec%0d.rx_param", i),   rx_if.rx_param, DEC ? vecs[i].exp_param : 1'b0);
            check($sformatf("vec%0d.display_on", i), display_on, DEC ? vecs[i].exp_disp : 1'b0);
            check($sformatf("vec%0d.contrast", i),   contrast, DEC ? vecs[i].exp_contrast : 8'h7F);
            check($sformatf("vec%0d.byte_count", i), byte_count, i + 1);
            pop_one();
            check($sformatf("vec%0d.empty_after_pop", i), rx_if.rx_valid, 0);
        end
        check("table.frame_err_count", fe_cnt, 0);
        ss = 1'b1;
        clks(4);
        check("table.clean_end_no_frame_err", fe_cnt, 0);

        // Overflow: five bytes into a depth-4 FIFO with no consumer
        do_reset();
        ss = 1'b0;
        clks(4);
        for (int k = 1; k <= 5; k++) begin
            send_bits(8'(k), 1'b1, 8);
            clks(4);
            if (k == 4) begin
                check("ovf.before_overflow", rx_overflow, 0);
                check("ovf.count_at_4", byte_count, 4);
            end
        end
        check("ovf.rx_overflow", rx_overflow, 1);
        check("ovf.byte_count", byte_count, 4);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf.pop%0d.valid", k), rx_if.rx_valid, 1);
            check($sformatf("ovf.pop%0d.data", k), rx_if.rx_data, k);
            pop_one();
        end
        check("ovf.drained", rx_if.rx_valid, 0);
        check("ovf.still_sticky", rx_overflow, 1);
        ss = 1'b1;
        clks(4);

        // Frame error: ss rises after 5 bits, then a full byte with rx_ready held high
        do_reset();
        fe_cnt = 0;
        ss = 1'b0;
        clks(4);
        send_bits(8'hA5, 1'b0, 5);
        clks(2);
        ss = 1'b1;
        clks(12);
        check("ferr.pulse_cycles", fe_cnt, 1);
        check("ferr.no_push", rx_if.rx_valid, 0);
        check("ferr.byte_count", byte_count, 0);
        ss = 1'b0;
        clks(4);
        pop_cnt = 0;
        rx_if.rx_ready = 1'b1;
        send_bits(8'h3C, 1'b0, 8);
        clks(8);
        rx_if.rx_ready = 1'b0;
        check("ferr.next_pops", pop_cnt, 1);
        check("ferr.next_data", last_pop, 8'h3C);
        check("ferr.next_count", byte_count, 1);
        check("ferr.drained", rx_if.rx_valid, 0);
        check("ferr.pulse_total", fe_cnt, 1);
        ss = 1'b1;
        clks(4);

        // Reset mid-byte, then no reception until a fresh ss fall
        do_reset();
        fe_cnt = 0;
        ss = 1'b0;
        clks(4);
        send_bits(8'h81, 1'b0, 8);
        send_bits(8'h44, 1'b0, 8);
        clks(4);
        check("rstmid.contrast_set", contrast, DEC ? 8'h44 : 8'h7F);
        check("rstmid.count_pre", byte_count, 2);
        send_bits(8'hFF, 1'b1, 4);
        rst = 1'b1;
        clks(2);
        check_reset_values("rstmid");
        clks(2);
        rst = 1'b0;
        send_bits(8'h5A, 1'b1, 8);
        clks(4);
        check("rstmid.no_rx_without_fall", rx_if.rx_valid, 0);
        check("rstmid.count_zero", byte_count, 0);
        ss = 1'b1;
        clks(6);
        check("rstmid.no_frame_err", fe_cnt, 0);
        ss = 1'b0;
        clks(4);
        send_bits(8'h3C, 1'b1, 8);
        wait_valid("rstmid.fresh.valid");
        check("rstmid.fresh.data", rx_if.rx_data, 8'h3C);
        check("rstmid.fresh.dc", rx_if.rx_dc, 1);
        check("rstmid.fresh.count", byte_count, 1);
        pop_one();
        ss = 1'b1;
        clks(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
